prefix_carry_pipe: RTL

PREFIX_CARRY_PIPE -- requirements
Module: prefix_carry_pipe

---
 rtl/prefix_carry_pipe.sv | 90 +++++++++
 1 files changed

// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry network: per-bit carries out, LVLS+1 stage latency.
// Define PREFIX_SUM_EN to add the sum output and its p/cin side pipeline.
module prefix_carry_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clkpos,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cout,
`ifdef PREFIX_SUM_EN
  output logic [WIDTH-1:0] sum,
`endif
  output logic             busy
);

  localparam int LVLS = $clog2(WIDTH);

  logic             en;
  logic [LVLS:0]    v_q, v_d;
  logic [WIDTH-1:0] g_q [LVLS+1];
  logic [WIDTH-1:0] g_d [LVLS+1];
  logic [WIDTH-1:0] p_q [LVLS];
  logic [WIDTH-1:0] p_d [LVLS];

  always_comb begin
    en  = !v_q[LVLS] | out_ready;
    v_d = {v_q[LVLS-1:0], in_valid};
    g_d[0]    = a & b;
    g_d[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    p_d[0]    = a ^ b;
    // Combine distance doubles each level; low bits pass through.
    for (int k = 1; k <= LVLS; k++) begin
      g_d[k] = g_q[k-1];
      for (int i = 1 << (k-1); i < WIDTH; i++) begin
        g_d[k][i] = g_q[k-1][i]
                  | (p_q[k-1][i] & g_q[k-1][i-(1 << (k-1))]);
      end
    end
    for (int k = 1; k < LVLS; k++) begin
      p_d[k] = p_q[k-1];
      for (int i = 1 << (k-1); i < WIDTH; i++) begin
        p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-(1 << (k-1))];
      end
    end
  end

  always_ff @(posedge clkpos) begin
    if (!rst_n) begin
      v_q <= '0;
      g_q <= '{default: '0};
      p_q <= '{default: '0};
    end else if (en) begin
      v_q <= v_d;
      g_q <= g_d;
      p_q <= p_d;
    end
  end

`ifdef PREFIX_SUM_EN
  logic [WIDTH-1:0] s_q [LVLS+1];
  logic [LVLS:0]    c_q;

  always_ff @(posedge clkpos) begin
    if (!rst_n) begin
      s_q <= '{default: '0};
      c_q <= '0;
    end else if (en) begin
      s_q[0] <= a ^ b;
      for (int k = 1; k <= LVLS; k++) begin
        s_q[k] <= s_q[k-1];
      end
      c_q <= {c_q[LVLS-1:0], cin};
    end
  end

  assign sum = s_q[LVLS] ^ {cout[WIDTH-2:0], c_q[LVLS]};
`endif

  assign in_ready  = en;
  assign out_valid = v_q[LVLS];
  assign cout      = g_q[LVLS];
  assign busy      = |v_q;

endmodule
